// File: rtl/line_extractor_pkg.sv
// Shared types and constants for the line extractor and its byte picker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package extract_pkg;

    localparam int LINE_BYTES = 16;
    localparam int OFFS_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        DONE = 2'd3
    } ext_state_t;

endpackage

// File: rtl/line_extractor_if.sv
// Load request, cache line read and load response bundle for the extractor.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready and resp_valid/resp_ready handshakes.
interface line_extractor_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_word;
    logic              req_sext;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_resp;
    logic [LINE_W-1:0] mem_rdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [15:0]       resp_data;

    // Environment side: CPU memory stage plus the cache read port.
    modport master (
        output req_valid, req_addr, req_word, req_sext,
        input  req_ready,
        input  mem_read, mem_address,
        output mem_resp, mem_rdata,
        input  resp_valid, resp_data,
        output resp_ready
    );

    // Extractor side.
    modport slave (
        input  req_valid, req_addr, req_word, req_sext,
        output req_ready,
        output mem_read, mem_address,
        input  mem_resp, mem_rdata,
        output resp_valid, resp_data,
        input  resp_ready
    );
endinterface

// File: rtl/line_extractor_byte_picker.sv
// Selects one byte out of a little-endian cache line by byte offset.
// Latency: combinational.
// Backpressure: none.
module byte_picker
    import extract_pkg::*;
#(
    parameter int LINE_W = LINE_BYTES * 8
) (
    input  logic [LINE_W-1:0] line,
    input  logic [OFFS_W-1:0] offs,
    output logic [7:0]        dat
);

    // Byte k sits at bits [8k+7:8k].
    always_comb dat = line[{offs, 3'b000} +: 8];

endmodule

// File: rtl/line_extractor.sv
// Fetches the line(s) holding a byte/word load and returns 16 extended bits.
// Latency: 2 cycles accept->resp_valid with an immediate cache reply, 3 for a line-crossing word.
// Backpressure: one load in flight; req_ready only in IDLE, DONE holds until resp_ready.
module line_extractor
    import extract_pkg::*;
#(
    parameter int LINE_W = LINE_BYTES * 8,
    parameter int ADDR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    line_extractor_if.slave  bus
);

    localparam int IDX_W = ADDR_W - OFFS_W;

    ext_state_t        state;
    ext_state_t        state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              word_q;
    logic              sext_q;
    logic              cross_q;
    logic [7:0]        lo_q;
    logic [7:0]        hi_q;

    logic [OFFS_W-1:0] offs;
    logic [OFFS_W-1:0] hi_offs;
    logic [IDX_W-1:0]  line_idx;
    logic [IDX_W-1:0]  line_idx_nxt;
    logic [7:0]        lo_pick;
    logic [7:0]        hi_pick;

    assign offs         = addr_q[OFFS_W-1:0];
    assign line_idx     = addr_q[ADDR_W-1:OFFS_W];
    // Second line of a crossing word; wraps from the top line to line 0.
    assign line_idx_nxt = line_idx + {{(IDX_W-1){1'b0}}, 1'b1};
    // In RD1 the high byte is byte 0 of the next line, otherwise the byte after offs.
    assign hi_offs      = (state == RD1) ? '0 : offs + OFFS_W'(1);

    byte_picker #(.LINE_W(LINE_W)) u_pick_lo (
        .line (bus.mem_rdata),
        .offs (offs),
        .dat  (lo_pick)
    );

    byte_picker #(.LINE_W(LINE_W)) u_pick_hi (
        .line (bus.mem_rdata),
        .offs (hi_offs),
        .dat  (hi_pick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; mem_resp only matters while a read is outstanding.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.req_valid)  state_nxt = RD0;
            RD0:  if (bus.mem_resp)   state_nxt = cross_q ? RD1 : DONE;
            RD1:  if (bus.mem_resp)   state_nxt = DONE;
            DONE: if (bus.resp_ready) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Request capture and byte capture from returning lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            word_q  <= 1'b0;
            sext_q  <= 1'b0;
            cross_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                addr_q  <= bus.req_addr;
                word_q  <= bus.req_word;
                sext_q  <= bus.req_sext;
                cross_q <= bus.req_word & (&bus.req_addr[OFFS_W-1:0]);
            end
            if (state == RD0 && bus.mem_resp) begin
                lo_q <= lo_pick;
                if (word_q && !cross_q) hi_q <= hi_pick;
            end
            if (state == RD1 && bus.mem_resp) begin
                hi_q <= hi_pick;
            end
        end
    end

    // Outputs decoded from state and registered data only.
    always_comb begin
        bus.req_ready   = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_address = '0;
        bus.resp_valid  = 1'b0;
        bus.resp_data   = '0;
        case (state)
            IDLE: bus.req_ready = 1'b1;
            RD0: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = {line_idx, {OFFS_W{1'b0}}};
            end
            RD1: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = {line_idx_nxt, {OFFS_W{1'b0}}};
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                if (word_q)      bus.resp_data = {hi_q, lo_q};
                else if (sext_q) bus.resp_data = {{8{lo_q[7]}}, lo_q};
                else             bus.resp_data = {8'h00, lo_q};
            end
            default: ;
        endcase
    end

endmodule
